mem_wb: RTL and testbench
=========================

MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- valid_i  in  1  instruction from EX/MEM present this cycle.
- reg_write_i  in  1  instruction writes rd.
- is_load_i  in  1  instruction is a load; data comes from memory response.
- load_funct3_i  in  3  load type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- addr_lo_i  in  2  load byte address bits [1:0].
- alu_result_i  in  32  non-load writeback value.
- writebackaddr_i  in  5  destination register rd.
- mem_rvalid_i  in  1  load data valid, single-cycle pulse.
- mem_rdata_i  in  32  aligned 32-bit load word.
- w_en  out  1  register-file write strobe, one-cycle pulse, to ID.
- w_addr  out  5  register-file write address, to ID w_addr.
- w_data  out  32  register-file write data, to ID w_data.
- stall_o  out  1  upstream SHALL hold its stage while high.
- retired_cnt_o  out  32  retired-instruction count (present only with the macro in REQ-020).

Function
REQ-002 The FSM SHALL have two states: IDLE and WAIT_LOAD.
REQ-003 In IDLE, valid_i=1, is_load_i=0 and reg_write_i=1 SHALL produce w_en=1, w_addr=writebackaddr_i and w_data=alu_result_i on the next cycle (latency 1).
REQ-004 In IDLE, valid_i=1 with is_load_i=1 SHALL capture writebackaddr_i, load_funct3_i, addr_lo_i and reg_write_i, and SHALL enter WAIT_LOAD.
REQ-005 stall_o SHALL equal (state==WAIT_LOAD); it is registered.
REQ-006 In WAIT_LOAD, valid_i SHALL be ignored.
REQ-007 In WAIT_LOAD, mem_rvalid_i=1 SHALL produce, on the next cycle, w_en=1, w_addr set to the captured rd and w_data set to the extracted value; the FSM SHALL return to IDLE on that same edge.
REQ-008 A new instruction SHALL be accepted in IDLE on the cycle w_en pulses for the previous load.
REQ-009 Extraction: lb/lbu SHALL select byte mem_rdata_i[8*addr_lo+7 -: 8]; lh/lhu SHALL select halfword [16*addr_lo[1]+15 -: 16].
REQ-010 lb and lh SHALL sign-extend; lbu and lhu SHALL zero-extend.
REQ-011 lw and funct3 values 011/110/111 SHALL pass the full word.
REQ-012 For lh/lhu, addr_lo[0] SHALL be ignored (no misalignment trap).
REQ-013 rd=0, or reg_write_i=0, SHALL suppress w_en; a load with either condition still SHALL wait for mem_rvalid_i.
REQ-014 mem_rvalid_i in IDLE SHALL be ignored and SHALL have no side effect.
REQ-015 w_addr and w_data SHALL hold their last written values when w_en=0.
REQ-016 In IDLE, valid_i=0 SHALL leave the state unchanged and w_en=0.

Reset
REQ-017 Reset SHALL force state=IDLE, w_en=0, w_addr=0, w_data=0, stall_o=0 and retired_cnt_o=0 on the next edge.
REQ-018 Reset asserted during WAIT_LOAD SHALL discard the pending load; a mem_rvalid_i arriving in the reset cycle or afterwards SHALL NOT write.
REQ-019 valid_i SHALL be ignored during the reset cycle.

Configuration
REQ-020 With MEM_WB_RETIRE_CNT_EN defined, retired_cnt_o SHALL increment by 1 per retired instruction: each accepted non-load in IDLE and each load completion, including rd=0 and reg_write_i=0 cases.
REQ-021 The counter SHALL be 32 bits and wrap 0xFFFFFFFF to 0.
REQ-022 Without MEM_WB_RETIRE_CNT_EN, the port and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 ALU write: valid_i=1, reg_write_i=1, rd=5, alu_result_i=0x12345678 -> next cycle w_en=1, w_addr=5, w_data=0x12345678; following cycle w_en=0.
REQ-024 lb sign: load rd=3, funct3=000, addr_lo=2; two cycles later mem_rvalid_i=1 with mem_rdata_i=0x0080FF11 -> stall_o high from the cycle after acceptance until the write; then w_data=0xFFFFFF80, w_addr=3; stall_o=0 the same cycle.
REQ-025 lhu/lw: funct3=101, addr_lo=2, rdata=0x8001BEEF -> w_data=0x00008001; funct3=010 with the same rdata -> w_data=0x8001BEEF.
REQ-026 x0 and stray response: load with rd=0 plus rvalid -> no w_en, FSM returns to IDLE; mem_rvalid_i in IDLE -> no w_en, state unchanged.
REQ-027 Reset mid-load: reset asserted in WAIT_LOAD, mem_rvalid_i in the next cycle -> no w_en, stall_o=0, outputs zero.
REQ-028 Counter (macro defined): 3 ALU ops + 1 load (rd=0) -> retired_cnt_o=4; preload to 0xFFFFFFFF and retire 1 -> 0.

Source files
------------

// File: rtl/mem_wb.sv
// Purpose : MEM/WB stage. Retires ALU results directly and holds a load until
//           its memory response arrives, then extracts and extends the load value.
// Latency : 1 cycle from an accepted ALU op, or from mem_rvalid_i, to the w_en pulse.
// Backpressure: stall_o is high for the whole time a load is outstanding. While it
//           is high, valid_i is ignored.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   valid_i, reg_write_i,          instruction from EX/MEM
//   is_load_i, load_funct3_i,
//   addr_lo_i, alu_result_i,
//   writebackaddr_i
//   mem_rvalid_i, mem_rdata_i      single-cycle load response (aligned word)
//   w_en, w_addr, w_data           register-file write port toward ID
//   stall_o                        upstream hold while a load is outstanding
//   retired_cnt_o                  retired-instruction counter (MEM_WB_RETIRE_CNT_EN only)
//
// Build option: define MEM_WB_RETIRE_CNT_EN to add the 32-bit retired counter.
module mem_wb (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic        reg_write_i,
   input  logic        is_load_i,
   input  logic [2:0]  load_funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] alu_result_i,
   input  logic [4:0]  writebackaddr_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        w_en,
   output logic [4:0]  w_addr,
   output logic [31:0] w_data,
   output logic        stall_o
`ifdef MEM_WB_RETIRE_CNT_EN
   ,
   output logic [31:0] retired_cnt_o
`endif
);

   typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        w_en_q, w_en_d;
   logic [4:0]  w_addr_q, w_addr_d;
   logic [31:0] w_data_q, w_data_d;

   // Context of the outstanding load
   logic [4:0]  ld_rd_q, ld_rd_d;
   logic [2:0]  ld_f3_q, ld_f3_d;
   logic [1:0]  ld_lo_q, ld_lo_d;
   logic        ld_rw_q, ld_rw_d;

   // Select the addressed byte/halfword and extend it. For halfwords only
   // addr_lo[1] matters, so odd halfword addresses do not trap.
   function automatic logic [31:0] extract(input logic [2:0]  f3,
                                           input logic [1:0]  lo,
                                           input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'd0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'd0, h};
         default: r = word;            // lw and the unused encodings
      endcase
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      ld_rd_d  = ld_rd_q;
      ld_f3_d  = ld_f3_q;
      ld_lo_d  = ld_lo_q;
      ld_rw_d  = ld_rw_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               if (is_load_i) begin
                  ld_rd_d = writebackaddr_i;
                  ld_f3_d = load_funct3_i;
                  ld_lo_d = addr_lo_i;
                  ld_rw_d = reg_write_i;
                  state_d = WAIT_LOAD;
               end else if (reg_write_i && (writebackaddr_i != 5'd0)) begin
                  w_en_d   = 1'b1;
                  w_addr_d = writebackaddr_i;
                  w_data_d = alu_result_i;
               end
            end
         end
         WAIT_LOAD: begin
            // A load to x0 or with reg_write clear still waits for its
            // response, so upstream stays in step with memory.
            if (mem_rvalid_i) begin
               state_d = IDLE;
               if (ld_rw_q && (ld_rd_q != 5'd0)) begin
                  w_en_d   = 1'b1;
                  w_addr_d = ld_rd_q;
                  w_data_d = extract(ld_f3_q, ld_lo_q, mem_rdata_i);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         w_en_q   <= 1'b0;
         w_addr_q <= 5'd0;
         w_data_q <= 32'd0;
         ld_rd_q  <= 5'd0;
         ld_f3_q  <= 3'd0;
         ld_lo_q  <= 2'd0;
         ld_rw_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
         ld_rd_q  <= ld_rd_d;
         ld_f3_q  <= ld_f3_d;
         ld_lo_q  <= ld_lo_d;
         ld_rw_q  <= ld_rw_d;
      end
   end

   assign w_en    = w_en_q;
   assign w_addr  = w_addr_q;
   assign w_data  = w_data_q;
   assign stall_o = (state_q == WAIT_LOAD);

`ifdef MEM_WB_RETIRE_CNT_EN
   // An instruction retires when a non-load is accepted or a load completes,
   // whether or not it actually writes the register file.
   logic        retire;
   logic [31:0] retired_cnt_q;

   assign retire = ((state_q == IDLE) && valid_i && !is_load_i) ||
                   ((state_q == WAIT_LOAD) && mem_rvalid_i);

   always_ff @(posedge clk) begin
      if (reset) begin
         retired_cnt_q <= 32'd0;
      end else if (retire) begin
         retired_cnt_q <= retired_cnt_q + 32'd1;   // wraps naturally
      end
   end

   assign retired_cnt_o = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb. Expected writebacks are queued as stimulus is
// driven; each cycle the observed w_en is compared against the queue, and
// each write is popped and compared.
module tb_mem_wb;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic        reg_write_i;
   logic        is_load_i;
   logic [2:0]  load_funct3_i;
   logic [1:0]  addr_lo_i;
   logic [31:0] alu_result_i;
   logic [4:0]  writebackaddr_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        w_en;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        stall_o;
`ifdef MEM_WB_RETIRE_CNT_EN
   logic [31:0] retired_cnt_o;
`endif

   mem_wb dut (
      .clk             (clk),
      .reset           (reset),
      .valid_i         (valid_i),
      .reg_write_i     (reg_write_i),
      .is_load_i       (is_load_i),
      .load_funct3_i   (load_funct3_i),
      .addr_lo_i       (addr_lo_i),
      .alu_result_i    (alu_result_i),
      .writebackaddr_i (writebackaddr_i),
      .mem_rvalid_i    (mem_rvalid_i),
      .mem_rdata_i     (mem_rdata_i),
      .w_en            (w_en),
      .w_addr          (w_addr),
      .w_data          (w_data),
      .stall_o         (stall_o)
`ifdef MEM_WB_RETIRE_CNT_EN
      ,
      .retired_cnt_o   (retired_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wb_t;

   wb_t q[$];
   int  checks   = 0;
   int  failures = 0;

   // Pending load context kept by the bench
   logic       p_rw;
   logic [4:0] p_rd;
   logic [2:0] p_f3;
   logic [1:0] p_lo;

   // Reference extraction written as shifts rather than muxes
   function automatic logic [31:0] ref_load(input logic [2:0]  f3,
                                            input logic [1:0]  lo,
                                            input logic [31:0] word);
      logic [31:0] sb, sh;
      sb = word >> (lo * 8);
      sh = word >> (lo[1] ? 16 : 0);
      case (f3)
         3'b000:  return {{24{sb[7]}}, sb[7:0]};
         3'b100:  return {24'h0, sb[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; sample 1 time unit after the edge and score the write port.
   task automatic tick();
      wb_t e;
      logic exp_we;
      @(posedge clk);
      #1;
      exp_we = (q.size() != 0);
      chk("w_en", {31'd0, w_en}, {31'd0, exp_we});
      if (exp_we) begin
         e = q.pop_front();
         chk("w_addr", {27'd0, w_addr}, {27'd0, e.a});
         chk("w_data", w_data, e.d);
      end
   endtask

   task automatic alu_op(input logic rw, input logic [4:0] rd, input logic [31:0] val);
      valid_i = 1'b1; is_load_i = 1'b0; reg_write_i = rw;
      writebackaddr_i = rd; alu_result_i = val;
      if (rw && rd != 5'd0) q.push_back('{a: rd, d: val});
      tick();
      valid_i = 1'b0;
   endtask

   task automatic load_issue(input logic rw, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [1:0] lo);
      valid_i = 1'b1; is_load_i = 1'b1; reg_write_i = rw;
      writebackaddr_i = rd; load_funct3_i = f3; addr_lo_i = lo;
      p_rw = rw; p_rd = rd; p_f3 = f3; p_lo = lo;
      tick();
      valid_i = 1'b0; is_load_i = 1'b0;
      chk("stall_after_issue", {31'd0, stall_o}, 32'd1);
   endtask

   task automatic load_resp(input logic [31:0] word);
      mem_rvalid_i = 1'b1; mem_rdata_i = word;
      if (p_rw && p_rd != 5'd0) q.push_back('{a: p_rd, d: ref_load(p_f3, p_lo, word)});
      tick();
      mem_rvalid_i = 1'b0;
      chk("stall_after_resp", {31'd0, stall_o}, 32'd0);
   endtask

   initial begin
      logic [2:0] f3_tab [8];
      f3_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

      reset = 1'b1; valid_i = 1'b0; reg_write_i = 1'b0; is_load_i = 1'b0;
      load_funct3_i = 3'd0; addr_lo_i = 2'd0; alu_result_i = 32'd0;
      writebackaddr_i = 5'd0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_w_addr", {27'd0, w_addr}, 32'd0);
      chk("rst_w_data", w_data, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);

      // ALU write, then hold of the write port
      alu_op(1'b1, 5'd5, 32'h12345678);
      tick();
      chk("hold_w_addr", {27'd0, w_addr}, 32'd5);
      chk("hold_w_data", w_data, 32'h12345678);

      // lb with sign extension; an instruction offered while waiting is ignored
      load_issue(1'b1, 5'd3, 3'b000, 2'd2);
      valid_i = 1'b1; reg_write_i = 1'b1; writebackaddr_i = 5'd7; alu_result_i = 32'hDEAD0007;
      tick();
      valid_i = 1'b0;
      chk("stall_wait", {31'd0, stall_o}, 32'd1);
      load_resp(32'h0080FF11);
      chk("lb_value", w_data, 32'hFFFFFF80);

      // Back-to-back: lhu accepted in the cycle the previous write pulses
      load_issue(1'b1, 5'd4, 3'b101, 2'd2);
      load_resp(32'h8001BEEF);
      chk("lhu_value", w_data, 32'h00008001);
      load_issue(1'b1, 5'd6, 3'b010, 2'd0);
      load_resp(32'h8001BEEF);
      // lh with addr_lo[0] set is treated as the aligned halfword
      load_issue(1'b1, 5'd8, 3'b001, 2'd3);
      load_resp(32'h9234ABCD);
      chk("lh_odd_value", w_data, 32'hFFFF9234);

      // Sweep of load types and byte offsets
      for (int i = 0; i < 16; i++) begin
         load_issue(1'b1, 5'($urandom_range(1, 31)), f3_tab[i % 8], 2'($urandom_range(0, 3)));
         load_resp($urandom);
      end

      // Load to x0 and a load with reg_write clear: both wait, neither writes
      load_issue(1'b1, 5'd0, 3'b010, 2'd0);
      tick();
      chk("x0_still_waiting", {31'd0, stall_o}, 32'd1);
      load_resp(32'hCAFEF00D);
      load_issue(1'b0, 5'd9, 3'b010, 2'd0);
      load_resp(32'h11112222);
      // Stray response in IDLE, ALU op with reg_write clear, ALU op to x0
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
      tick();
      mem_rvalid_i = 1'b0;
      chk("stray_stall", {31'd0, stall_o}, 32'd0);
      alu_op(1'b0, 5'd10, 32'hAAAA0000);
      alu_op(1'b1, 5'd0, 32'hBBBB0000);
      alu_op(1'b1, 5'd31, 32'h0000FFFF);

      // Reset while a load is pending; response arrives in and after reset
      load_issue(1'b1, 5'd9, 3'b010, 2'd0);
      reset = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77777777;
      tick();
      reset = 1'b0;
      tick();
      mem_rvalid_i = 1'b0;
      chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_mid_w_addr", {27'd0, w_addr}, 32'd0);
      chk("rst_mid_w_data", w_data, 32'd0);

      // valid_i during the reset cycle is ignored
      reset = 1'b1; valid_i = 1'b1; is_load_i = 1'b0; reg_write_i = 1'b1;
      writebackaddr_i = 5'd12; alu_result_i = 32'h12121212;
      tick();
      reset = 1'b0; valid_i = 1'b0;
      tick();
      chk("rst_valid_w_data", w_data, 32'd0);

`ifdef MEM_WB_RETIRE_CNT_EN
      chk("cnt_reset", retired_cnt_o, 32'd0);
      alu_op(1'b1, 5'd1, 32'd1);
      alu_op(1'b0, 5'd2, 32'd2);
      alu_op(1'b1, 5'd3, 32'd3);
      load_issue(1'b1, 5'd0, 3'b010, 2'd0);
      load_resp(32'h0);
      chk("cnt_four", retired_cnt_o, 32'd4);
      dut.retired_cnt_q = 32'hFFFFFFFF;
      alu_op(1'b1, 5'd4, 32'd4);
      chk("cnt_wrap", retired_cnt_o, 32'd0);
`endif

      tick();
      chk("queue_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
